// File: rtl/dbg_run_ctrl.sv
// Debug run controller: drives the IF-stage stall to implement halt, free run,
// step-N and PC breakpoints, and counts executed fetch cycles.
module dbg_run_ctrl #(
  parameter int NUM_BP = 4,
  parameter int IDX_W  = 2,
  parameter int STEP_W = 16
) (
  input  logic             clk_cpu,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      pc,
  output logic             stall,
  output logic             halted,
  output logic             bp_hit,
  output logic [IDX_W-1:0] bp_idx,
  output logic             step_done,
  output logic             cmd_err,
  output logic [31:0]      instr_cnt
);
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_BREAK  = 2'd3
  } state_t;

  localparam logic [2:0] OP_HALT    = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_SET_BP  = 3'd3;
  localparam logic [2:0] OP_CLR_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_ALL = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;
  localparam logic [31:0] NUM_BP_U  = 32'(NUM_BP);

  state_t            state_q, state_d;
  logic [NUM_BP-1:0] bp_vld_q, bp_vld_d;
  logic [31:0]       bp_addr_q [NUM_BP];
  logic [STEP_W-1:0] step_q, step_d;
  logic              skip_q, skip_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  bp_idx_q, bp_idx_d;
  logic              hit_q, hit_d, done_q, done_d, err_q, err_d;

  logic [NUM_BP-1:0] hit_vec_s;
  logic              match_s;
  logic [IDX_W-1:0]  match_idx_s;
  logic              active_s, accept_s, idx_oor_s, bad_s, ok_s;
  logic              exec_s, brk_s, fin_s, set_bp_s;

  // Breakpoint compare; descending scan leaves the lowest matching slot.
  always_comb begin
    hit_vec_s   = '0;
    match_idx_s = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      hit_vec_s[i] = bp_vld_q[i] && (bp_addr_q[i] == pc);
      match_idx_s  = hit_vec_s[i] ? IDX_W'(i) : match_idx_s;
    end
    match_s = |hit_vec_s;
  end

  // Handshake, stall and command classification.
  always_comb begin
    active_s  = (state_q == ST_RUN) || (state_q == ST_STEP);
    stall     = active_s ? (match_s && !skip_q) : 1'b1;
    halted    = !active_s;
    cmd_ready = active_s ? !((cmd_op == OP_RUN) || (cmd_op == OP_STEP)) : 1'b1;
    accept_s  = cmd_valid && cmd_ready;
    idx_oor_s = ({{(32-IDX_W){1'b0}}, cmd_idx} >= NUM_BP_U) &&
                ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP));
    bad_s     = accept_s && ((cmd_op == OP_RSVD) || idx_oor_s);
    ok_s      = accept_s && !bad_s;
    exec_s    = active_s && !stall;
    brk_s     = active_s && stall;
    fin_s     = (state_q == ST_STEP) && exec_s && (step_q == STEP_W'(1));
    set_bp_s  = ok_s && (cmd_op == OP_SET_BP);
  end

  // Next-state: an accepted HALT overrides break entry and step completion.
  always_comb begin
    state_d  = state_q;
    bp_vld_d = bp_vld_q;
    bp_idx_d = bp_idx_q;
    hit_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    skip_d   = exec_s ? 1'b0 : skip_q;
    cnt_d    = exec_s ? (cnt_q + 32'd1) : cnt_q;
    step_d   = ((state_q == ST_STEP) && exec_s) ? (step_q - STEP_W'(1)) : step_q;
    if (ok_s && (cmd_op == OP_HALT)) begin
      state_d = ST_HALTED;
    end else if (brk_s) begin
      state_d  = ST_BREAK;
      hit_d    = 1'b1;
      bp_idx_d = match_idx_s;
      step_d   = '0;
    end else if (fin_s) begin
      state_d = ST_HALTED;
      done_d  = 1'b1;
    end else begin
      state_d = state_q;
    end
    if (ok_s) begin
      case (cmd_op)
        OP_RUN: begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end
        OP_STEP: begin
          state_d = ST_STEP;
          skip_d  = 1'b1;
          step_d  = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];
        end
        OP_SET_BP: begin
          for (int i = 0; i < NUM_BP; i++) begin
            bp_vld_d[i] = (cmd_idx == IDX_W'(i)) ? 1'b1 : bp_vld_d[i];
          end
        end
        OP_CLR_BP: begin
          for (int i = 0; i < NUM_BP; i++) begin
            bp_vld_d[i] = (cmd_idx == IDX_W'(i)) ? 1'b0 : bp_vld_d[i];
          end
        end
        OP_CLR_ALL: bp_vld_d = '0;
        OP_CLR_CNT: cnt_d = 32'd0;
        default:    err_d = 1'b0;
      endcase
    end else begin
      err_d = bad_s;
    end
  end

  // State and control registers.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_HALTED;
      bp_vld_q <= '0;
      step_q   <= '0;
      skip_q   <= 1'b0;
      cnt_q    <= 32'd0;
      bp_idx_q <= '0;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bp_vld_q <= bp_vld_d;
      step_q   <= step_d;
      skip_q   <= skip_d;
      cnt_q    <= cnt_d;
      bp_idx_q <= bp_idx_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Breakpoint address storage.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (set_bp_s && (cmd_idx == IDX_W'(i))) bp_addr_q[i] <= cmd_arg;
      end
    end
  end

  assign bp_hit    = hit_q;
  assign bp_idx    = bp_idx_q;
  assign step_done = done_q;
  assign cmd_err   = err_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl (3 breakpoint slots): directed vector table, corner
// sequences and randomized commands against a per-cycle reference model.
module tb_dbg_run_ctrl;
  localparam int NUM_BP = 3;
  localparam logic [2:0] OP_HALT = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_SET = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4, OP_CLRALL = 3'd5, OP_CLRCNT = 3'd6, OP_RSVD = 3'd7;
  localparam int M_HALTED = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3;

  logic        clk_cpu = 1'b0, rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [1:0]  cmd_idx = 2'd0;
  logic [31:0] cmd_arg = 32'd0, pc, instr_cnt;
  logic        stall, halted, bp_hit, step_done, cmd_err;
  logic [1:0]  bp_idx;

  int n_total = 0, n_bad = 0;

  // reference model
  int          m_mode, m_step;
  bit          m_skip, m_hit, m_done, m_err;
  bit          m_bv [NUM_BP];
  logic [31:0] m_ba [NUM_BP];
  logic [31:0] m_cnt;
  logic [1:0]  m_bpidx;

  dbg_run_ctrl #(.NUM_BP(NUM_BP), .IDX_W(2), .STEP_W(16)) dut (
    .clk_cpu(clk_cpu), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .pc(pc), .stall(stall),
    .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx), .step_done(step_done),
    .cmd_err(cmd_err), .instr_cnt(instr_cnt));

  always #5 clk_cpu = ~clk_cpu;

  // fetch-stage PC: advance one word per unstalled cycle, loop inside a window
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) pc <= 32'h3000;
    else if (!stall) pc <= (pc == 32'h30FC) ? 32'h3000 : pc + 32'd4;
  end

  typedef struct {
    bit v; logic [2:0] op; logic [1:0] idx; logic [31:0] arg;
    bit rdy, stl, hlt, hit; logic [1:0] bidx; bit done, err; logic [31:0] cnt, pcv;
  } vec_t;
  vec_t tv [30];

  function automatic vec_t mk(bit v, logic [2:0] op, logic [1:0] idx, logic [31:0] arg,
                              bit rdy, bit stl, bit hlt, bit hit, logic [1:0] bidx,
                              bit done, bit err, logic [31:0] cnt, logic [31:0] pcv);
    vec_t r;
    r.v = v; r.op = op; r.idx = idx; r.arg = arg; r.rdy = rdy; r.stl = stl; r.hlt = hlt;
    r.hit = hit; r.bidx = bidx; r.done = done; r.err = err; r.cnt = cnt; r.pcv = pcv;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_HALTED; m_step = 0; m_skip = 0; m_hit = 0; m_done = 0; m_err = 0;
    m_cnt = 32'd0; m_bpidx = 2'd0;
    for (int i = 0; i < NUM_BP; i++) begin m_bv[i] = 0; m_ba[i] = 32'd0; end
  endfunction

  // One clock: drive at negedge, compare against the model, step the model at posedge.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [1:0] idx, input logic [31:0] arg);
    bit mt, active, e_stall, e_ready, acc, bad, ex, brk, fin;
    logic [1:0] mi;
    cmd_valid = v; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
    #2;
    mt = 0; mi = 2'd0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (m_bv[i] && m_ba[i] == pc) begin mt = 1; mi = 2'(i); end
    active  = (m_mode == M_RUN) || (m_mode == M_STEP);
    e_stall = active ? (mt && !m_skip) : 1'b1;
    e_ready = active ? !(op == OP_RUN || op == OP_STEP) : 1'b1;
    check("model", 64'({stall, cmd_ready, halted, bp_hit, bp_idx, step_done, cmd_err, instr_cnt}),
          64'({e_stall, e_ready, !active, m_hit, m_bpidx, m_done, m_err, m_cnt}));
    @(posedge clk_cpu);
    acc = v && e_ready;
    bad = acc && (op == OP_RSVD || ((op == OP_SET || op == OP_CLR) && int'(idx) >= NUM_BP));
    ex  = active && !e_stall;
    brk = active && e_stall;
    fin = (m_mode == M_STEP) && ex && (m_step == 1);
    m_hit = 0; m_done = 0; m_err = bad;
    if (ex) begin m_cnt = m_cnt + 32'd1; m_skip = 0; if (m_mode == M_STEP) m_step--; end
    if (acc && !bad && op == OP_HALT) m_mode = M_HALTED;
    else if (brk) begin m_mode = M_BREAK; m_hit = 1; m_bpidx = mi; end
    else if (fin) begin m_mode = M_HALTED; m_done = 1; end
    if (acc && !bad) begin
      case (op)
        OP_RUN:    begin m_mode = M_RUN; m_skip = 1; end
        OP_STEP:   begin m_mode = M_STEP; m_skip = 1; m_step = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]); end
        OP_SET:    begin m_bv[idx] = 1; m_ba[idx] = arg; end
        OP_CLR:    m_bv[idx] = 0;
        OP_CLRALL: for (int i = 0; i < NUM_BP; i++) m_bv[i] = 0;
        OP_CLRCNT: m_cnt = 32'd0;
        default:   ;
      endcase
    end
    @(negedge clk_cpu);
  endtask

  task automatic idle();
    cycle(1'b0, OP_HALT, 2'd0, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #2;
    check("in_reset", 64'({stall, halted, bp_hit, step_done, cmd_err, instr_cnt}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
    @(negedge clk_cpu);
    rstn = 1'b1;
  endtask

  initial begin : main
    bit seen, reached;
    int ndone, nhit;
    logic [2:0] rop;
    logic [31:0] rarg;

    tv[0]  = mk(0, OP_HALT,   0, 0,          1,1,1,0,0,0,0, 0, 32'h3000);
    tv[1]  = mk(0, OP_HALT,   0, 0,          1,1,1,0,0,0,0, 0, 32'h3000);
    tv[2]  = mk(1, OP_STEP,   0, 3,          1,1,1,0,0,0,0, 0, 32'h3000);
    tv[3]  = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 0, 32'h3000);
    tv[4]  = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 1, 32'h3004);
    tv[5]  = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 2, 32'h3008);
    tv[6]  = mk(0, OP_HALT,   0, 0,          1,1,1,0,0,1,0, 3, 32'h300C);
    tv[7]  = mk(0, OP_HALT,   0, 0,          1,1,1,0,0,0,0, 3, 32'h300C);
    tv[8]  = mk(1, OP_STEP,   0, 0,          1,1,1,0,0,0,0, 3, 32'h300C);
    tv[9]  = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 3, 32'h300C);
    tv[10] = mk(0, OP_HALT,   0, 0,          1,1,1,0,0,1,0, 4, 32'h3010);
    tv[11] = mk(1, OP_CLRCNT, 0, 0,          1,1,1,0,0,0,0, 4, 32'h3010);
    tv[12] = mk(1, OP_SET,    1, 32'h3020,   1,1,1,0,0,0,0, 0, 32'h3010);
    tv[13] = mk(1, OP_RUN,    0, 0,          1,1,1,0,0,0,0, 0, 32'h3010);
    tv[14] = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 0, 32'h3010);
    tv[15] = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 1, 32'h3014);
    tv[16] = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 2, 32'h3018);
    tv[17] = mk(0, OP_HALT,   0, 0,          1,0,0,0,0,0,0, 3, 32'h301C);
    tv[18] = mk(0, OP_HALT,   0, 0,          1,1,0,0,0,0,0, 4, 32'h3020);
    tv[19] = mk(0, OP_HALT,   0, 0,          1,1,1,1,1,0,0, 4, 32'h3020);
    tv[20] = mk(1, OP_RUN,    0, 0,          1,1,1,0,1,0,0, 4, 32'h3020);
    tv[21] = mk(0, OP_HALT,   0, 0,          1,0,0,0,1,0,0, 4, 32'h3020);
    tv[22] = mk(1, OP_RUN,    0, 0,          0,0,0,0,1,0,0, 5, 32'h3024);
    tv[23] = mk(1, OP_HALT,   0, 0,          1,0,0,0,1,0,0, 6, 32'h3028);
    tv[24] = mk(0, OP_HALT,   0, 0,          1,1,1,0,1,0,0, 7, 32'h302C);
    tv[25] = mk(1, OP_RSVD,   0, 0,          1,1,1,0,1,0,0, 7, 32'h302C);
    tv[26] = mk(0, OP_HALT,   0, 0,          1,1,1,0,1,0,1, 7, 32'h302C);
    tv[27] = mk(1, OP_SET,    3, 32'h302C,   1,1,1,0,1,0,0, 7, 32'h302C);
    tv[28] = mk(0, OP_HALT,   0, 0,          1,1,1,0,1,0,1, 7, 32'h302C);
    tv[29] = mk(0, OP_HALT,   0, 0,          1,1,1,0,1,0,0, 7, 32'h302C);

    model_reset();
    #1;
    check("reset_state", 64'({stall, halted, bp_hit, step_done, cmd_err, bp_idx, instr_cnt}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0}));
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    rstn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      cmd_valid = tv[i].v; cmd_op = tv[i].op; cmd_idx = tv[i].idx; cmd_arg = tv[i].arg;
      #1;
      check($sformatf("vec%0d", i),
            64'({cmd_ready, stall, halted, bp_hit, bp_idx, step_done, cmd_err, instr_cnt}),
            64'({tv[i].rdy, tv[i].stl, tv[i].hlt, tv[i].hit, tv[i].bidx, tv[i].done, tv[i].err, tv[i].cnt}));
      check($sformatf("vec%0d_pc", i), 64'(pc), 64'(tv[i].pcv));
      cycle(tv[i].v, tv[i].op, tv[i].idx, tv[i].arg);
    end

    // two slots on one address: lowest index reports, pending steps are dropped
    cycle(1'b1, OP_SET, 2'd0, 32'h3038);
    cycle(1'b1, OP_SET, 2'd2, 32'h3038);
    cycle(1'b1, OP_STEP, 2'd0, 32'd10);
    seen = 0; ndone = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle();
      if (step_done) ndone++;
      if (bp_hit) begin
        seen = 1;
        check("dup_bp_idx", 64'(bp_idx), 64'd0);
        check("dup_bp_pc", 64'(pc), 64'h3038);
      end
    end
    check("dup_bp_seen", 64'(seen), 64'd1);
    check("dup_bp_no_step_done", 64'(ndone), 64'd0);

    // HALT arriving in the cycle the PC reaches a breakpoint
    cycle(1'b1, OP_SET, 2'd1, 32'h3044);
    cycle(1'b1, OP_RUN, 2'd0, 32'd0);
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (pc == 32'h3044 && !halted) begin
        reached = 1;
        cycle(1'b1, OP_HALT, 2'd0, 32'd0);
      end else begin
        idle();
      end
    end
    check("halt_vs_bp_reached", 64'(reached), 64'd1);
    check("halt_vs_bp", 64'({halted, stall, bp_hit, bp_idx}), 64'({1'b1, 1'b1, 1'b0, 2'd0}));
    idle();

    // asynchronous reset in the middle of a STEP
    cycle(1'b1, OP_STEP, 2'd0, 32'd5);
    idle();
    idle();
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst", 64'({stall, halted, instr_cnt}), 64'({1'b1, 1'b1, 32'd0}));
    model_reset();
    @(negedge clk_cpu);
    rstn = 1'b1;
    cycle(1'b1, OP_RUN, 2'd0, 32'd0);
    nhit = 0;
    for (int k = 0; k < 30; k++) begin
      idle();
      if (bp_hit) nhit++;
    end
    check("bp_cleared_by_rst", 64'({nhit, pc}), 64'({32'd0, 32'h3078}));
    cycle(1'b1, OP_HALT, 2'd0, 32'd0);

    // randomized commands against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        rop  = 3'($urandom_range(0, 7));
        rarg = (rop == OP_STEP) ? 32'($urandom_range(0, 12)) : 32'h3000 + 32'(4 * $urandom_range(0, 63));
        cycle(($urandom_range(0, 2) == 0), rop, 2'($urandom_range(0, 3)), rarg);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
Debug run controller that sequences the CPU fetch stage through the stall input of the PC register. It executes debug-unit commands: halt, free run, step N instructions, and set/clear PC breakpoints. It also counts retired fetch cycles. It sits between the serial debug command decoder and the IF stage; the pc input taps the current PC value.

Parameters:
NUM_BP, 4, number of PC breakpoint slots (1..8)
IDX_W, 2, width of breakpoint slot index; must satisfy 2**IDX_W >= NUM_BP
STEP_W, 16, width of step counter

Ports:
clk_cpu  in  1  CPU clock
rstn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  3  0 HALT, 1 RUN, 2 STEP, 3 SET_BP, 4 CLR_BP, 5 CLR_ALL_BP, 6 CLR_CNT, 7 reserved
cmd_idx  in  IDX_W  breakpoint slot for SET_BP/CLR_BP
cmd_arg  in  32  BP address (SET_BP) or step count (STEP, low STEP_W bits)
pc  in  32  current PC of the fetch stage
stall  out  1  to IF stage; 1 = hold PC
halted  out  1  state is HALTED or BREAK
bp_hit  out  1  one-cycle pulse on entry to BREAK
bp_idx  out  IDX_W  slot that caused the last break; held until the next break
step_done  out  1  one-cycle pulse when a STEP completes
cmd_err  out  1  one-cycle pulse on an accepted reserved op or an out-of-range index
instr_cnt  out  32  executed-cycle count; wraps 0xFFFFFFFF -> 0

Behaviour:
- States: HALTED, RUN, STEP, BREAK. Reset state is HALTED.
- Reset values: all BP slots invalid; step_cnt=0; skip=0; instr_cnt=0; bp_idx=0; all pulse outputs 0. stall=1 and halted=1 during reset.
- "Executed cycle" = cycle with state in {RUN, STEP} and stall=0.
- match = any valid slot with addr==pc. The lowest matching index wins.
- stall is combinational: 1 in HALTED and BREAK; in RUN and STEP, stall = match & ~skip. stall never depends on the command presented in the same cycle.
- skip: set when RUN or STEP is accepted. Cleared on the first executed cycle. This lets execution resume from a breakpointed PC.
- RUN/STEP with match & ~skip: next state BREAK, bp_hit pulses, bp_idx latched. For STEP, the remaining step_cnt is discarded.
- Command acceptance:
  - cmd_ready=1 in HALTED and BREAK.
  - In RUN and STEP, cmd_ready=0 only when cmd_op is RUN or STEP; RUN and STEP are blocked until halted.
- HALT: next state HALTED from any state. HALT has priority over breakpoint entry and step completion in the same cycle; in that case bp_hit and step_done do not pulse. The instruction executing in that cycle still counts.
- RUN: next state RUN.
- STEP: load step_cnt = arg (0 treated as 1); next state STEP. Each executed cycle decrements step_cnt. An executed cycle with step_cnt==1 gives next state HALTED and a step_done pulse.
- SET_BP: slot cmd_idx := {valid=1, addr=cmd_arg}. Effective from the next cycle; no state change.
- CLR_BP: invalidate slot cmd_idx.
- CLR_ALL_BP: invalidate all slots.
- CLR_CNT: instr_cnt := 0. Same-cycle increment is lost.
- Any cmd_idx >= NUM_BP, or op 7: no state or register effect; cmd_err pulses.
- instr_cnt increments by 1 on each executed cycle.
- Async reset mid-RUN or mid-STEP: immediate return to reset values; stall=1.

Test Plan:
- Reset, PC model at 0x3000, no commands -> stall=1, halted=1 indefinitely; instr_cnt=0; PC stays 0x3000.
- STEP arg=3 from 0x3000 -> exactly 3 cycles with stall=0; PC ends at 0x300C; step_done pulses once; halted=1; instr_cnt=3. STEP arg=0 -> 1 instruction.
- SET_BP idx1=0x3010, then RUN from 0x3000 -> 4 executed cycles; stall=1 with PC=0x3010; bp_hit pulse; bp_idx=1. Then RUN -> PC passes 0x3010 without re-break.
- SET_BP idx0=0x3008 and idx2=0x3008, STEP 10 -> break at 0x3008 with bp_idx=0; step_done never pulses.
- During RUN: assert RUN -> cmd_ready=0. HALT in the same cycle the PC reaches a breakpoint -> HALTED; no bp_hit pulse.
- Op 7, and SET_BP with idx=3 under NUM_BP=3 -> cmd_err pulses; breakpoint set unchanged. rstn low mid-STEP -> stall=1 immediately; breakpoints cleared.
